rst_req_ctrl: RTL and testbench
===============================

# rst_req_ctrl

Always-on reset request controller that sits in front of the SoC clock/reset generator. It collects reset requests from software, the watchdog and an external pin, drives the active-low reset input of the generator for a bounded, acknowledged interval, and records the cause. It is the requesting end of the reset path: the generator synchronizes and distributes the reset, and this block initiates it and confirms entry and exit through the synchronized domain reset it receives back.

## Interface
- HOLD_CYCLES, 16: cycles the request stays asserted after the domain acknowledges reset entry (1..2^CNT_W-1).
- ACK_TIMEOUT, 255: maximum cycles to wait for each domain acknowledge (1..2^CNT_W-1).
- CNT_W, 8: width of the internal down-counter.
- clk_i  in  1  always-on clock.
- rst_i  in  1  synchronous, active-high reset.
- sw_req_i  in  1  software reset request, single-cycle pulse.
- wdt_req_i  in  1  watchdog reset request, level or pulse.
- ext_req_i  in  1  external reset request, already synchronized to clk_i.
- domain_rstn_i  in  1  synchronized reset of the target domain, active-low. This is the acknowledge.
- cause_clr_i  in  1  clears cause_o and timeout_o.
- rstn_req_o  out  1  active-low reset request to the clock/reset generator.
- busy_o  out  1  high while a sequence is in progress.
- cause_o  out  3  sticky cause bits: {ext, wdt, sw}.
- timeout_o  out  1  sticky, set when any acknowledge wait times out.
- req_count_o  out  8  number of sequences started, saturating at 255.

## Operation
- The FSM has four states: IDLE, ASSERT, HOLD and RELEASE.
- IDLE
  - Trigger condition: any of sw_req_i, wdt_req_i or ext_req_i is high.
  - On a trigger, OR all active request bits into cause_o.
  - Increment req_count_o; it saturates at 255.
  - Load the counter with ACK_TIMEOUT and go to ASSERT.
- ASSERT
  - rstn_req_o = 0.
  - If domain_rstn_i == 0, load HOLD_CYCLES and go to HOLD.
  - Otherwise decrement the counter. When it reaches 0, set timeout_o, load HOLD_CYCLES and go to HOLD.
- HOLD
  - rstn_req_o = 0.
  - Decrement the counter. When it reaches 0, load ACK_TIMEOUT and go to RELEASE.
- RELEASE
  - rstn_req_o = 1.
  - If domain_rstn_i == 1, go to IDLE.
  - Otherwise decrement the counter. When it reaches 0, set timeout_o and go to IDLE.
- Requests arriving while not in IDLE are ignored: they do not trigger, update cause or increment the count.
- A level request still high on return to IDLE starts a new sequence.
- busy_o = (state != IDLE).
- cause_clr_i clears cause_o and timeout_o.
  - If it coincides with a new trigger or a timeout, the set wins for the newly set bits.
  - Bits that are not being set are still cleared.
- Simultaneous requests start one sequence, and every active cause bit is recorded.
- All outputs are registered.

## Timing
- Reset values while rst_i is high, and on the first cycle after it falls:
  - state IDLE
  - rstn_req_o = 1
  - busy_o = 0
  - cause_o = 3'b000
  - timeout_o = 0
  - req_count_o = 0
  - counter = 0
- rst_i mid-sequence aborts immediately: rstn_req_o returns to 1 on the next edge.
- Latency:
  - A request sampled high at edge N gives rstn_req_o = 0, busy_o = 1 and updated cause_o/req_count_o after edge N.
  - rstn_req_o stays low for (ack latency + 1) + HOLD_CYCLES cycles, where ack latency is the cycles from rstn_req_o falling to the first edge that samples domain_rstn_i = 0.
  - With an immediate acknowledge, the minimum low time is HOLD_CYCLES + 1 cycles.
- Timeout timing:
  - An ASSERT timeout fires on the ACK_TIMEOUT-th cycle without an acknowledge; timeout_o rises with the entry into HOLD.
  - A RELEASE timeout fires the same way; timeout_o rises with the entry into IDLE.
- The earliest re-trigger is the cycle after entering IDLE, so back-to-back sequences are separated by at least one cycle with rstn_req_o = 1 plus the RELEASE time.
- Each wait state applies one decrement per cycle. The counter never wraps: exit is taken when it reaches 0.

## Test plan
- **Basic sequence:** HOLD_CYCLES=4, one-cycle sw_req_i pulse, domain_rstn_i falls 3 cycles after rstn_req_o falls and rises 2 cycles after rstn_req_o rises.
  - Expect rstn_req_o low for 8 cycles.
  - Expect busy_o high for 11 cycles.
  - Expect cause_o = 3'b001 and req_count_o = 1.
- **Simultaneous requests:** sw_req_i and ext_req_i pulsed in the same cycle.
  - Expect exactly one sequence, cause_o = 3'b101 and req_count_o increments by 1.
  - A wdt_req_i pulse during HOLD leaves cause_o unchanged.
- **Missing acknowledge:** ACK_TIMEOUT=10 with domain_rstn_i stuck high.
  - Expect timeout_o to set on the 10th ASSERT cycle.
  - Expect HOLD to still run HOLD_CYCLES.
  - Expect release to wait 10 more cycles only if domain_rstn_i is stuck low.
- **Clear versus set:** assert cause_clr_i in the same cycle as a wdt_req_i trigger while cause_o = 3'b001.
  - Expect cause_o = 3'b010 afterwards.
  - Expect timeout_o cleared if it was not being set in that cycle.
- **Counter saturation and level re-trigger:** hold wdt_req_i high for 300 sequences.
  - Expect back-to-back sequences.
  - Expect req_count_o to stop at 255.
- **Reset mid-sequence:** assert rst_i while in HOLD.
  - Expect rstn_req_o = 1, busy_o = 0, cause_o = 0, timeout_o = 0 and req_count_o = 0 at the next edge.
  - Expect no sequence to resume after rst_i falls unless a request is present.

Source files
------------

// File: rtl/rst_req_ctrl.sv
// Purpose: collects sw/wdt/ext reset requests and drives an acknowledged, bounded
//          active-low reset request to the clock/reset generator.
// Latency: a request sampled at edge N shows as rstn_req_o=0/busy_o=1 after edge N.
// Backpressure: none; requests arriving while busy are ignored, and a level request
//          still high on return to IDLE starts a new sequence.
//
// Ports:
//   clk_i, rst_i        always-on clock, synchronous active-high reset
//   sw_req_i            software request (pulse)
//   wdt_req_i           watchdog request (level or pulse)
//   ext_req_i           external request (pre-synchronized)
//   domain_rstn_i       synchronized domain reset fed back as the acknowledge
//   cause_clr_i         clears cause_o and timeout_o
//   rstn_req_o          active-low reset request to the generator
//   busy_o              sequence in progress
//   cause_o             sticky {ext, wdt, sw}
//   timeout_o           sticky acknowledge-timeout flag
//   req_count_o         sequences started, saturating at 255
module rst_req_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sw_req_i,
  input  logic       wdt_req_i,
  input  logic       ext_req_i,
  input  logic       domain_rstn_i,
  input  logic       cause_clr_i,
  output logic       rstn_req_o,
  output logic       busy_o,
  output logic [2:0] cause_o,
  output logic       timeout_o,
  output logic [7:0] req_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ACK_LD  = CNT_W'(ACK_TIMEOUT);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rstn_req_q;
  logic             busy_q;
  logic [2:0]       cause_q,   cause_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       count_q,   count_d;

  logic [2:0] req_vec;
  logic       trig;
  logic       cnt_last;
  logic       ack_to;

  assign req_vec = {ext_req_i, wdt_req_i, sw_req_i};
  assign trig    = (state_q == IDLE) && (req_vec != 3'b000);

  // This cycle's decrement lands on zero. Treating 0 the same as 1 means a
  // counter that is somehow already 0 exits instead of wrapping.
  assign cnt_last = (cnt_q <= CNT_W'(1));

  // Acknowledge wait expires without the expected domain_rstn_i level.
  assign ack_to = cnt_last &&
                  (((state_q == ASSERT)  &&  domain_rstn_i) ||
                   ((state_q == RELEASE) && !domain_rstn_i));

  // Clear drops every bit; bits being set in the same cycle win.
  always_comb begin
    cause_d   = (cause_q & ~{3{cause_clr_i}}) | (trig ? req_vec : 3'b000);
    timeout_d = (timeout_q & ~cause_clr_i) | ack_to;
    count_d   = count_q;
    if (trig && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rstn_req_q <= 1'b1;
      busy_q     <= 1'b0;
      cause_q    <= 3'b000;
      timeout_q  <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      cause_q   <= cause_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q    <= ASSERT;
            cnt_q      <= ACK_LD;
            rstn_req_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ASSERT: begin
          // Acknowledge or timeout both move on to the hold interval.
          if (!domain_rstn_i || cnt_last) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_last) begin
            state_q    <= RELEASE;
            cnt_q      <= ACK_LD;
            rstn_req_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (domain_rstn_i || cnt_last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          rstn_req_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rstn_req_o  = rstn_req_q;
  assign busy_o      = busy_q;
  assign cause_o     = cause_q;
  assign timeout_o   = timeout_q;
  assign req_count_o = count_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Bench for rst_req_ctrl: a domain model answers rstn_req_o with programmable
// fall/rise delays (or stuck levels); each sequence is judged against durations,
// cause and count predicted from the controller's rules.
module tb_rst_req_ctrl;

  localparam int HOLD = 4;
  localparam int ACK  = 10;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       sw_req_i = 1'b0;
  logic       wdt_req_i = 1'b0;
  logic       ext_req_i = 1'b0;
  logic       domain_rstn_i = 1'b1;
  logic       cause_clr_i = 1'b0;
  logic       rstn_req_o;
  logic       busy_o;
  logic [2:0] cause_o;
  logic       timeout_o;
  logic [7:0] req_count_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [2:0] exp_cause = 3'b000;
  logic       exp_to = 1'b0;
  int         exp_count = 0;

  // Domain model controls: 0 follow with delays, 1 stuck high, 2 stuck low
  int dmode = 0;
  int fall_dly = 0;
  int rise_dly = 0;
  int low_cnt = 0;
  int high_cnt = 0;

  rst_req_ctrl #(
    .HOLD_CYCLES(HOLD),
    .ACK_TIMEOUT(ACK),
    .CNT_W(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .sw_req_i(sw_req_i),
    .wdt_req_i(wdt_req_i),
    .ext_req_i(ext_req_i),
    .domain_rstn_i(domain_rstn_i),
    .cause_clr_i(cause_clr_i),
    .rstn_req_o(rstn_req_o),
    .busy_o(busy_o),
    .cause_o(cause_o),
    .timeout_o(timeout_o),
    .req_count_o(req_count_o)
  );

  always #5 clk = ~clk;

  // Generator model: the domain reset follows rstn_req_o after fall_dly/rise_dly cycles.
  always @(negedge clk) begin
    if (rstn_req_o) begin
      high_cnt = high_cnt + 1;
      low_cnt  = 0;
    end else begin
      low_cnt  = low_cnt + 1;
      high_cnt = 0;
    end
    case (dmode)
      1: domain_rstn_i = 1'b1;
      2: domain_rstn_i = 1'b0;
      default: begin
        if (!rstn_req_o && (low_cnt > fall_dly)) domain_rstn_i = 1'b0;
        else if (rstn_req_o && (high_cnt > rise_dly)) domain_rstn_i = 1'b1;
      end
    endcase
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running, need done");
    $fatal(1);
  end

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // Starts at a negedge where busy_o is high; counts busy/low cycles until busy_o
  // drops. Optionally pulses a request mask at index 2 and cause_clr_i at clr_at.
  task automatic measure(input logic [2:0] inj, input int clr_at,
                         output int low_n, output int busy_n, output int to_idx);
    bit done;
    done = 1'b0;
    low_n = 0; busy_n = 0; to_idx = -1;
    for (int i = 0; i < 2000; i++) begin
      if (timeout_o && to_idx < 0) to_idx = i;
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
      busy_n++;
      if (!rstn_req_o) low_n++;
      if (inj != 3'b000) begin
        if (i == 2) {ext_req_i, wdt_req_i, sw_req_i} = inj;
        if (i == 3) {ext_req_i, wdt_req_i, sw_req_i} = 3'b000;
      end
      if (i == clr_at) cause_clr_i = 1'b1;
      if (i == clr_at + 1) cause_clr_i = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL seq_end: busy_o still high after 2000 cycles, need low");
    end
  endtask

  task automatic trigger(input logic [2:0] mask);
    @(negedge clk);
    {ext_req_i, wdt_req_i, sw_req_i} = mask;
    @(negedge clk);
    {ext_req_i, wdt_req_i, sw_req_i} = 3'b000;
  endtask

  task automatic clear_causes();
    @(negedge clk);
    cause_clr_i = 1'b1;
    @(negedge clk);
    cause_clr_i = 1'b0;
    exp_cause = 3'b000;
    exp_to = 1'b0;
    vectors++;
    if ({cause_o, timeout_o} !== {exp_cause, exp_to}) begin
      miscompares++;
      $display("FAIL clear: cause/timeout got %b/%b need %b/%b", cause_o, timeout_o, exp_cause, exp_to);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rstn_req_o, busy_o, cause_o, timeout_o, req_count_o} !== {1'b1, 1'b0, 3'b000, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_held: rstn/busy/cause/to/count got %b/%b/%b/%b/%0d need 1/0/000/0/0",
               rstn_req_o, busy_o, cause_o, timeout_o, req_count_o);
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rstn_req_o, busy_o, cause_o, timeout_o, req_count_o} !== {1'b1, 1'b0, 3'b000, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_after: rstn/busy/cause/to/count got %b/%b/%b/%b/%0d need 1/0/000/0/0",
               rstn_req_o, busy_o, cause_o, timeout_o, req_count_o);
    end
    exp_cause = 3'b000; exp_to = 1'b0; exp_count = 0;
  endtask

  task automatic test_basic();
    int low_n, busy_n, to_idx;
    dmode = 0; fall_dly = 3; rise_dly = 2;
    clear_causes();
    trigger(3'b001);
    exp_count = sat_inc(exp_count);
    measure(3'b000, -1, low_n, busy_n, to_idx);
    vectors++;
    if (low_n != 8) begin
      miscompares++;
      $display("FAIL basic_low: rstn_req_o low %0d cycles, need 8", low_n);
    end
    vectors++;
    if (busy_n != 11) begin
      miscompares++;
      $display("FAIL basic_busy: busy_o high %0d cycles, need 11", busy_n);
    end
    vectors++;
    if ({cause_o, req_count_o, timeout_o} !== {3'b001, 8'(exp_count), 1'b0}) begin
      miscompares++;
      $display("FAIL basic_cause: cause/count/to got %b/%0d/%b need 001/%0d/0",
               cause_o, req_count_o, timeout_o, exp_count);
    end
  endtask

  task automatic test_simultaneous();
    int low_n, busy_n, to_idx;
    dmode = 0; fall_dly = 0; rise_dly = 0;
    clear_causes();
    trigger(3'b101);
    exp_count = sat_inc(exp_count);
    // wdt pulse lands while the controller is in HOLD
    measure(3'b010, -1, low_n, busy_n, to_idx);
    vectors++;
    if ({cause_o, req_count_o} !== {3'b101, 8'(exp_count)}) begin
      miscompares++;
      $display("FAIL simul_cause: cause/count got %b/%0d need 101/%0d", cause_o, req_count_o, exp_count);
    end
    vectors++;
    if (low_n != HOLD + 1) begin
      miscompares++;
      $display("FAIL simul_low: rstn_req_o low %0d cycles, need %0d", low_n, HOLD + 1);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ({busy_o, req_count_o} !== {1'b0, 8'(exp_count)}) begin
      miscompares++;
      $display("FAIL simul_single: busy/count got %b/%0d need 0/%0d", busy_o, req_count_o, exp_count);
    end
    exp_cause = 3'b101;
  endtask

  task automatic test_timeouts();
    int low_n, busy_n, to_idx;
    // Acknowledge never arrives during ASSERT
    clear_causes();
    dmode = 1;
    trigger(3'b001);
    exp_count = sat_inc(exp_count);
    measure(3'b000, -1, low_n, busy_n, to_idx);
    vectors++;
    if (to_idx != ACK) begin
      miscompares++;
      $display("FAIL assert_to_idx: timeout_o rose at cycle %0d, need %0d", to_idx, ACK);
    end
    vectors++;
    if ({low_n, busy_n} != {ACK + HOLD, ACK + HOLD + 1}) begin
      miscompares++;
      $display("FAIL assert_to_len: low/busy got %0d/%0d need %0d/%0d", low_n, busy_n, ACK + HOLD, ACK + HOLD + 1);
    end
    // Domain stuck in reset: RELEASE waits out its full timeout
    clear_causes();
    dmode = 2;
    trigger(3'b001);
    exp_count = sat_inc(exp_count);
    measure(3'b000, -1, low_n, busy_n, to_idx);
    dmode = 0;
    vectors++;
    if ({low_n, busy_n, to_idx} != {HOLD + 1, HOLD + 1 + ACK, HOLD + 1 + ACK}) begin
      miscompares++;
      $display("FAIL release_to: low/busy/to_idx got %0d/%0d/%0d need %0d/%0d/%0d",
               low_n, busy_n, to_idx, HOLD + 1, HOLD + 1 + ACK, HOLD + 1 + ACK);
    end
    vectors++;
    if ({cause_o, timeout_o} !== 4'b0011) begin
      miscompares++;
      $display("FAIL release_to_flags: cause/to got %b/%b need 001/1", cause_o, timeout_o);
    end
    exp_cause = 3'b001; exp_to = 1'b1;
  endtask

  task automatic test_clear_vs_set();
    int low_n, busy_n, to_idx;
    dmode = 0; fall_dly = 0; rise_dly = 0;
    // State here: cause 001, timeout 1
    @(negedge clk);
    wdt_req_i = 1'b1; cause_clr_i = 1'b1;
    @(negedge clk);
    wdt_req_i = 1'b0; cause_clr_i = 1'b0;
    exp_count = sat_inc(exp_count);
    vectors++;
    if ({cause_o, timeout_o, busy_o} !== {3'b010, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL clr_vs_trig: cause/to/busy got %b/%b/%b need 010/0/1", cause_o, timeout_o, busy_o);
    end
    measure(3'b000, -1, low_n, busy_n, to_idx);
    // Clear coinciding with an ASSERT timeout: timeout set wins, cause is cleared
    dmode = 1;
    trigger(3'b100);
    exp_count = sat_inc(exp_count);
    measure(3'b000, ACK - 1, low_n, busy_n, to_idx);
    dmode = 0;
    vectors++;
    if ({cause_o, timeout_o, to_idx} !== {3'b000, 1'b1, ACK}) begin
      miscompares++;
      $display("FAIL clr_vs_to: cause/to/to_idx got %b/%b/%0d need 000/1/%0d", cause_o, timeout_o, to_idx, ACK);
    end
    exp_cause = 3'b000; exp_to = 1'b1;
  endtask

  task automatic test_random();
    int low_n, busy_n, to_idx, want_low, want_busy;
    logic [2:0] mask, inj;
    dmode = 0;
    clear_causes();
    for (int n = 0; n < 40; n++) begin
      fall_dly = $urandom_range(0, ACK - 1);
      rise_dly = $urandom_range(0, ACK - 1);
      mask = 3'($urandom_range(1, 7));
      inj  = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 3) == 0) clear_causes();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      trigger(mask);
      exp_cause = exp_cause | mask;
      exp_count = sat_inc(exp_count);
      want_low  = fall_dly + 1 + HOLD;
      want_busy = want_low + rise_dly + 1;
      measure(inj, -1, low_n, busy_n, to_idx);
      vectors++;
      if ({low_n, busy_n} != {want_low, want_busy}) begin
        miscompares++;
        $display("FAIL rand_len[%0d]: low/busy got %0d/%0d need %0d/%0d (fall %0d rise %0d)",
                 n, low_n, busy_n, want_low, want_busy, fall_dly, rise_dly);
      end
      vectors++;
      if ({cause_o, timeout_o, req_count_o} !== {exp_cause, exp_to, 8'(exp_count)}) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: cause/to/count got %b/%b/%0d need %b/%b/%0d",
                 n, cause_o, timeout_o, req_count_o, exp_cause, exp_to, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    int low_n, busy_n, to_idx;
    bit restarted;
    dmode = 0; fall_dly = 0; rise_dly = 0;
    trigger(3'b001);
    @(negedge clk);
    @(negedge clk);  // now in HOLD
    rst_i = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rstn_req_o, busy_o, cause_o, timeout_o, req_count_o} !== {1'b1, 1'b0, 3'b000, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: rstn/busy/cause/to/count got %b/%b/%b/%b/%0d need 1/0/000/0/0",
               rstn_req_o, busy_o, cause_o, timeout_o, req_count_o);
    end
    rst_i = 1'b0;
    exp_cause = 3'b000; exp_to = 1'b0; exp_count = 0;
    restarted = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy_o || !rstn_req_o) restarted = 1'b1;
    end
    vectors++;
    if (restarted) begin
      miscompares++;
      $display("FAIL reset_noresume: sequence restarted after reset, need idle");
    end
    trigger(3'b010);
    exp_cause = 3'b010; exp_count = 1;
    vectors++;
    if ({busy_o, cause_o, req_count_o} !== {1'b1, exp_cause, 8'(exp_count)}) begin
      miscompares++;
      $display("FAIL reset_then_req: busy/cause/count got %b/%b/%0d need 1/010/1", busy_o, cause_o, req_count_o);
    end
    measure(3'b000, -1, low_n, busy_n, to_idx);
  endtask

  task automatic test_back_to_back();
    int low_n, busy_n, to_idx;
    dmode = 0; fall_dly = 0; rise_dly = 0;
    @(negedge clk);
    wdt_req_i = 1'b1;
    for (int s = 0; s < 300; s++) begin
      @(negedge clk);
      exp_count = sat_inc(exp_count);
      vectors++;
      if ({busy_o, req_count_o} !== {1'b1, 8'(exp_count)}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: busy/count got %b/%0d need 1/%0d", s, busy_o, req_count_o, exp_count);
      end
      if (s == 299) wdt_req_i = 1'b0;
      measure(3'b000, -1, low_n, busy_n, to_idx);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ({busy_o, req_count_o, cause_o} !== {1'b0, 8'd255, 3'b010}) begin
      miscompares++;
      $display("FAIL b2b_end: busy/count/cause got %b/%0d/%b need 0/255/010", busy_o, req_count_o, cause_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_timeouts();
    test_clear_vs_set();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
